// File: rtl/pll_md_ctrl_pkg.sv
// ============================================================================
// pll_md_pkg : shared MD opcodes, FSM state encoding and divider helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package pll_md_pkg;

  localparam logic [1:0] MD_NOP  = 2'b00;
  localparam logic [1:0] MD_WR   = 2'b01;
  localparam logic [1:0] MD_RD   = 2'b10;
  localparam logic [1:0] MD_ADDR = 2'b11;

  localparam logic [7:0] FB_ADDR_DEFAULT = 8'h04;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RST_HOLD  = 4'd1,
    ST_ADDR      = 4'd2,
    ST_WRITE     = 4'd3,
    ST_READ      = 4'd4,
    ST_CHECK     = 4'd5,
    ST_RELEASE   = 4'd6,
    ST_WAIT_LOCK = 4'd7,
    ST_DONE      = 4'd8,
    ST_FAIL      = 4'd9
  } state_e;

  // The feedback divider register holds multiplier minus one.
  function automatic logic [7:0] div_code(input logic [7:0] mult);
    return mult - 8'd1;
  endfunction

  function automatic logic [7:0] norm_mult(input logic [7:0] mult);
    return (mult == 8'd0) ? 8'd1 : mult;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pll_md_ctrl_if.sv
// ============================================================================
// pll_md_ctrl_if : config handshake, PLL reset/lock and MD port bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface pll_md_ctrl_if;
  logic       cfg_req;
  logic [7:0] cfg_mult;
  logic       cfg_ack;
  logic       pll_rst;
  logic       pll_lock;
  logic [1:0] mdopc;
  logic       mdainc;
  logic [7:0] mdwdi;
  logic [7:0] mdrdo;
  logic       lock;
  logic       busy;
  logic       err;

  modport master (
    input  cfg_req, cfg_mult, pll_lock, mdrdo,
    output cfg_ack, pll_rst, mdopc, mdainc, mdwdi, lock, busy, err
  );

  modport slave (
    output cfg_req, cfg_mult, pll_lock, mdrdo,
    input  cfg_ack, pll_rst, mdopc, mdainc, mdwdi, lock, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/pll_md_ctrl_sync.sv
// ============================================================================
// pll_lock_sync : two-flop synchronizer for the raw PLL lock, 0 in reset
// Rev 1.0
// ============================================================================
`default_nettype none

module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/pll_md_ctrl.sv
// ============================================================================
// pll_md_ctrl : programs the PLL feedback multiplier over the MD port, holds
//               PLL reset during the rewrite and qualifies lock with a timeout.
//               PLL_MD_READBACK_EN adds a read-back verify of the written value.
// Rev 1.0
// ============================================================================
`default_nettype none

module pll_md_ctrl
  import pll_md_pkg::*;
#(
  parameter int         DEFAULT_MULT = 18,
  parameter logic [7:0] FB_ADDR      = FB_ADDR_DEFAULT,
  parameter int         RST_CYCLES   = 16,
  parameter int         LOCK_TIMEOUT = 65535,
  parameter bit         AUTO_INIT    = 1'b1
) (
  input  logic           mdclk,
  input  logic           rst_n,
  pll_md_ctrl_if.master  bus
);

  localparam state_e      c_RESET_ST     = AUTO_INIT ? ST_RST_HOLD : ST_IDLE;
  localparam logic [7:0]  c_DEFAULT_MULT = 8'(DEFAULT_MULT);
  localparam logic [15:0] c_RST_LAST     = 16'(RST_CYCLES - 1);
  localparam logic [15:0] c_TO_LAST      = 16'(LOCK_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  mult_q, mult_d;
  logic        err_q, err_d;
  logic        ack_q, ack_d;
  logic        pll_rst_q, pll_rst_d;
  logic        busy_q, busy_d;
  logic [1:0]  mdopc_q, mdopc_d;
  logic [7:0]  mdwdi_q, mdwdi_d;
  logic        accept;
  logic        lock_sync;

  pll_lock_sync u_lock_sync (
    .clk_i   (mdclk),
    .rst_ni  (rst_n),
    .async_i (bus.pll_lock),
    .sync_o  (lock_sync)
  );

  // Outputs are registered from the next state so they stay at their reset
  // values while rst_n is low, even when the FSM resets into RST_HOLD.
  always_ff @(posedge mdclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= c_RESET_ST;
      cnt_q     <= 16'd0;
      mult_q    <= c_DEFAULT_MULT;
      err_q     <= 1'b0;
      ack_q     <= 1'b0;
      pll_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      mdopc_q   <= MD_NOP;
      mdwdi_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mult_q    <= mult_d;
      err_q     <= err_d;
      ack_q     <= ack_d;
      pll_rst_q <= pll_rst_d;
      busy_q    <= busy_d;
      mdopc_q   <= mdopc_d;
      mdwdi_q   <= mdwdi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mult_d  = mult_q;
    err_d   = err_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (bus.cfg_req) begin
          accept  = 1'b1;
          mult_d  = norm_mult(bus.cfg_mult);
          err_d   = 1'b0;
          cnt_d   = 16'd0;
          state_d = ST_RST_HOLD;
        end
      end
      ST_RST_HOLD: begin
        if (cnt_q == c_RST_LAST) begin
          cnt_d   = 16'd0;
          state_d = ST_ADDR;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_ADDR: state_d = ST_WRITE;
`ifdef PLL_MD_READBACK_EN
      ST_WRITE: state_d = ST_READ;
      ST_READ:  state_d = ST_CHECK;
      // mdrdo carries the answer to the read issued in the previous cycle.
      ST_CHECK: begin
        if (bus.mdrdo == div_code(mult_q)) begin
          state_d = ST_RELEASE;
        end else begin
          err_d   = 1'b1;
          state_d = ST_FAIL;
        end
      end
`else
      ST_WRITE: state_d = ST_RELEASE;
`endif
      ST_RELEASE: begin
        cnt_d   = 16'd0;
        state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_sync) begin
          cnt_d   = 16'd0;
          state_d = ST_DONE;
        end else if (cnt_q == c_TO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_FAIL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_d     = accept;
    pll_rst_d = 1'b1;
    busy_d    = 1'b1;
    mdopc_d   = MD_NOP;
    mdwdi_d   = 8'h00;
    case (state_d)
      ST_IDLE, ST_FAIL: busy_d = 1'b0;
      ST_DONE: begin
        busy_d    = 1'b0;
        pll_rst_d = 1'b0;
      end
      ST_ADDR: begin
        mdopc_d = MD_ADDR;
        mdwdi_d = FB_ADDR;
      end
      ST_WRITE: begin
        mdopc_d = MD_WR;
        mdwdi_d = div_code(mult_q);
      end
`ifdef PLL_MD_READBACK_EN
      ST_READ: mdopc_d = MD_RD;
`endif
      ST_RELEASE, ST_WAIT_LOCK: pll_rst_d = 1'b0;
      default: ;
    endcase
  end

  assign bus.cfg_ack = ack_q;
  assign bus.pll_rst = pll_rst_q;
  assign bus.mdopc   = mdopc_q;
  assign bus.mdainc  = 1'b0;
  assign bus.mdwdi   = mdwdi_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;
  // Drops together with the synchronized lock, without waiting for the FSM.
  assign bus.lock    = lock_sync & (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_pll_md_ctrl.sv
// ============================================================================
// tb_pll_md_ctrl : scoreboard bench for pll_md_ctrl with a PLL/MD behaviour model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_pll_md_ctrl;
  import pll_md_pkg::*;

`ifdef PLL_MD_READBACK_EN
  localparam bit c_RB = 1'b1;
`else
  localparam bit c_RB = 1'b0;
`endif
  localparam int c_RST_CYCLES = 16;
  localparam int c_LAT = c_RB ? (1 + c_RST_CYCLES + 4) : (c_RST_CYCLES + 3);

  typedef struct {
    logic [1:0] opc;
    logic [7:0] data;
    bit         chk_data;
  } md_exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int      n_checks = 0;
  int      n_fail   = 0;
  md_exp_t exp_q[$];
  md_exp_t mon_e;

  // Stimulus and PLL model state
  logic       req = 1'b0, req2 = 1'b0;
  logic [7:0] mult = 8'd0, mult2 = 8'd0;
  logic       rd_bad = 1'b0, glitch = 1'b0, lock_raw = 1'b0;
  int         lock_cnt = 0;
  int         lock_delay = 200;
  logic [7:0] m_addr = 8'h00, m_fb = 8'h00, m_rd = 8'h00;
  logic [7:0] m2_fb = 8'h00, m2_rd = 8'h00;

  pll_md_ctrl_if bus ();
  pll_md_ctrl_if bus2 ();

  assign bus.cfg_req   = req;
  assign bus.cfg_mult  = mult;
  assign bus.pll_lock  = lock_raw & ~glitch;
  assign bus.mdrdo     = m_rd;
  assign bus2.cfg_req  = req2;
  assign bus2.cfg_mult = mult2;
  assign bus2.pll_lock = 1'b0;
  assign bus2.mdrdo    = m2_rd;

  pll_md_ctrl #(
    .DEFAULT_MULT (18), .FB_ADDR (8'h04), .RST_CYCLES (c_RST_CYCLES),
    .LOCK_TIMEOUT (65535), .AUTO_INIT (1'b1)
  ) dut (.mdclk (clk), .rst_n (rst_n), .bus (bus.master));

  pll_md_ctrl #(
    .DEFAULT_MULT (18), .FB_ADDR (8'h04), .RST_CYCLES (c_RST_CYCLES),
    .LOCK_TIMEOUT (100), .AUTO_INIT (1'b0)
  ) dut_to (.mdclk (clk), .rst_n (rst_n), .bus (bus2.master));

  // PLL model plus MD scoreboard consumer, sampled on the falling edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (bus.pll_rst) begin
        lock_cnt = 0;
        lock_raw = 1'b0;
      end else if (lock_cnt < lock_delay) begin
        lock_cnt++;
      end else begin
        lock_raw = 1'b1;
      end
      case (bus.mdopc)
        MD_ADDR: m_addr = bus.mdwdi;
        MD_WR:   if (m_addr == 8'h04) m_fb = bus.mdwdi;
        MD_RD:   m_rd = rd_bad ? 8'h00 : m_fb;
        default: ;
      endcase
      if (bus2.mdopc == MD_WR) m2_fb = bus2.mdwdi;
      if (bus2.mdopc == MD_RD) m2_rd = m2_fb;
      if (bus.mdopc !== MD_NOP) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL md_unexpected: got opc=%b data=%h, expected no MD op", bus.mdopc, bus.mdwdi);
        end else begin
          mon_e = exp_q.pop_front();
          if (bus.mdopc !== mon_e.opc || (mon_e.chk_data && bus.mdwdi !== mon_e.data)) begin
            n_fail++;
            $display("FAIL md_trace: got opc=%b data=%h, expected opc=%b data=%h",
                     bus.mdopc, bus.mdwdi, mon_e.opc, mon_e.data);
          end
        end
      end
    end
  endtask

  task automatic push_trace(input logic [7:0] code);
    exp_q.push_back('{opc: MD_ADDR, data: 8'h04, chk_data: 1'b1});
    exp_q.push_back('{opc: MD_WR,   data: code,  chk_data: 1'b1});
    if (c_RB) exp_q.push_back('{opc: MD_RD, data: 8'h00, chk_data: 1'b0});
  endtask

  task automatic wait_lock(output bit got);
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.lock === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cfg_ack === 1'b1) begin
        got = 1'b1;
        req = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.pll_rst, bus.mdopc, bus.mdainc, bus.mdwdi, bus.cfg_ack, bus.lock, bus.busy, bus.err}
        !== {1'b1, 2'b00, 1'b0, 8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_main: rst=%b opc=%b inc=%b wdi=%h ack=%b lock=%b busy=%b err=%b, expected 1 00 0 00 0 0 0 0",
               bus.pll_rst, bus.mdopc, bus.mdainc, bus.mdwdi, bus.cfg_ack, bus.lock, bus.busy, bus.err);
    end
    n_checks++;
    if ({bus2.pll_rst, bus2.mdopc, bus2.mdainc, bus2.mdwdi, bus2.cfg_ack, bus2.lock, bus2.busy, bus2.err}
        !== {1'b1, 2'b00, 1'b0, 8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_to: rst=%b opc=%b wdi=%h ack=%b busy=%b err=%b, expected 1 00 00 0 0 0",
               bus2.pll_rst, bus2.mdopc, bus2.mdwdi, bus2.cfg_ack, bus2.busy, bus2.err);
    end
  endtask

  task automatic test_auto_init();
    int hold = 0;
    bit got;
    push_trace(8'h11);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.pll_rst) hold++;
      else break;
    end
    n_checks++;
    if (hold < c_RST_CYCLES) begin
      n_fail++;
      $display("FAIL auto_rst_hold: pll_rst high %0d cycles, expected >= %0d", hold, c_RST_CYCLES);
    end
    wait_lock(got);
    n_checks++;
    if (!got || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.pll_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL auto_done: lock=%b busy=%b err=%b pll_rst=%b, expected 1 0 0 0",
               bus.lock, bus.busy, bus.err, bus.pll_rst);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL auto_trace_drain: %0d MD ops outstanding, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reconfig();
    int  acks = 0, first_ack = 0, lat = 0;
    logic rst_at_ack = 1'b0;
    bit  got;
    @(negedge clk);
    push_trace(8'h18);
    req  = 1'b1;
    mult = 8'd25;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (bus.cfg_ack) begin
        acks++;
        if (first_ack == 0) begin
          first_ack  = i;
          rst_at_ack = bus.pll_rst;
        end
        req = 1'b0;
      end
      if (lat == 0 && acks > 0 && bus.pll_rst == 1'b0) lat = i;
    end
    n_checks++;
    if (acks != 1 || first_ack != 1) begin
      n_fail++;
      $display("FAIL reconfig_ack: %0d ack cycles first at %0d, expected 1 at 1", acks, first_ack);
    end
    n_checks++;
    if (rst_at_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL reconfig_rst_reassert: pll_rst=%b at ack, expected 1", rst_at_ack);
    end
    n_checks++;
    if (lat != c_LAT) begin
      n_fail++;
      $display("FAIL reconfig_release_latency: %0d cycles, expected %0d", lat, c_LAT);
    end
    wait_lock(got);
    n_checks++;
    if (!got || bus.err !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reconfig_relock: lock=%b err=%b pending=%0d, expected 1 0 0", bus.lock, bus.err, exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int t_rel = -1, t_err = -1;
    @(negedge clk);
    req2  = 1'b1;
    mult2 = 8'd10;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus2.cfg_ack) req2 = 1'b0;
      if (t_rel < 0 && bus2.pll_rst == 1'b0) t_rel = i;
      if (bus2.err) begin
        t_err = i;
        break;
      end
    end
    n_checks++;
    if (t_rel < 0 || t_err < 0 || (t_err - t_rel) != 101) begin
      n_fail++;
      $display("FAIL timeout_cycles: release at %0d err at %0d, expected err 101 after release", t_rel, t_err);
    end
    n_checks++;
    if (bus2.pll_rst !== 1'b1 || bus2.lock !== 1'b0 || bus2.busy !== 1'b0 || bus2.err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_fail_state: pll_rst=%b lock=%b busy=%b err=%b, expected 1 0 0 1",
               bus2.pll_rst, bus2.lock, bus2.busy, bus2.err);
    end
  endtask

  task automatic test_readback_fail();
    bit acked = 1'b0, released = 1'b0;
    @(negedge clk);
    rd_bad = 1'b1;
    push_trace(8'h1D);
    req  = 1'b1;
    mult = 8'd30;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.cfg_ack) begin
        acked = 1'b1;
        req   = 1'b0;
      end else if (acked && bus.pll_rst == 1'b0) begin
        released = 1'b1;
      end
      if (bus.err) break;
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.pll_rst == 1'b0) released = 1'b1;
    end
    n_checks++;
    if (bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.lock !== 1'b0) begin
      n_fail++;
      $display("FAIL readback_err: err=%b busy=%b lock=%b, expected 1 0 0", bus.err, bus.busy, bus.lock);
    end
    n_checks++;
    if (released || bus.pll_rst !== 1'b1) begin
      n_fail++;
      $display("FAIL readback_rst_held: released=%b pll_rst=%b, expected 0 1", released, bus.pll_rst);
    end
    rd_bad = 1'b0;
  endtask

  task automatic test_req_while_busy();
    bit got, found = 1'b0, seen_done = 1'b0, ack_seen = 1'b0;
    logic rst_at_ack = 1'b0;
    @(negedge clk);
    push_trace(8'h13);
    req  = 1'b1;
    mult = 8'd20;
    wait_ack(got);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.pll_rst == 1'b0) break;
    end
    push_trace(8'h15);
    req  = 1'b1;
    mult = 8'd22;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.cfg_ack) begin
        ack_seen   = 1'b1;
        rst_at_ack = bus.pll_rst;
        break;
      end
      if (bus.lock && !bus.busy) seen_done = 1'b1;
    end
    req = 1'b0;
    n_checks++;
    if (!got || !ack_seen || !seen_done || rst_at_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_req_deferred: first_ack=%b ack=%b done_before_ack=%b pll_rst=%b, expected 1 1 1 1",
               got, ack_seen, seen_done, rst_at_ack);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.mdopc === MD_WR) begin
        found = 1'b1;
        break;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (!found || {bus.pll_rst, bus.mdopc, bus.mdainc, bus.mdwdi, bus.cfg_ack, bus.lock, bus.busy, bus.err}
        !== {1'b1, 2'b00, 1'b0, 8'h00, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_in_write: saw_wr=%b rst=%b opc=%b wdi=%h ack=%b lock=%b busy=%b err=%b, expected 1 1 00 00 0 0 0 0",
               found, bus.pll_rst, bus.mdopc, bus.mdwdi, bus.cfg_ack, bus.lock, bus.busy, bus.err);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    push_trace(8'h11);
    rst_n = 1'b1;
    wait_lock(got);
    n_checks++;
    if (!got || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_reinit: lock=%b pending=%0d, expected 1 0", bus.lock, exp_q.size());
    end
  endtask

  task automatic test_mult_zero_glitch();
    bit got_ack, got;
    logic [3:0] seq;
    @(negedge clk);
    push_trace(8'h00);
    req  = 1'b1;
    mult = 8'd0;
    wait_ack(got_ack);
    wait_lock(got);
    n_checks++;
    if (!got_ack || !got || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mult_zero: ack=%b lock=%b pending=%0d, expected 1 1 0", got_ack, got, exp_q.size());
    end
    @(negedge clk);
    glitch = 1'b1;
    @(negedge clk); seq[3] = bus.lock;
    @(negedge clk); seq[2] = bus.lock;
    glitch = 1'b0;
    @(negedge clk); seq[1] = bus.lock;
    @(negedge clk); seq[0] = bus.lock;
    n_checks++;
    if (seq !== 4'b1001) begin
      n_fail++;
      $display("FAIL lock_sync_delay: lock sequence %b, expected 1001", seq);
    end
    #1 glitch = 1'b1;
    #2 glitch = 1'b0;
    @(negedge clk); seq[1] = bus.lock;
    @(negedge clk); seq[0] = bus.lock;
    n_checks++;
    if (seq[1:0] !== 2'b11 || bus.busy !== 1'b0 || bus.pll_rst !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_short_glitch: lock=%b busy=%b pll_rst=%b, expected 11 0 0",
               seq[1:0], bus.busy, bus.pll_rst);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_auto_init();
    test_reconfig();
    test_timeout();
`ifdef PLL_MD_READBACK_EN
    test_readback_fail();
`endif
    test_req_while_busy();
    test_mult_zero_glitch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded 2 ms, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/pll_md_ctrl.md
Name: pll_md_ctrl

Overview:
Sequencer for the Gowin PLL dynamic-reconfiguration (MD) port and its reset/lock handshake. It replaces the vendor init helper: it programs the feedback multiplier after power-up and on request, holds PLL reset during the rewrite, and qualifies lock with a timeout. It sits between the PLL wrapper (reset, lock, mdopc/mdainc/mdwdi/mdrdo) and system logic. It runs entirely in the mdclk domain.

Parameters:
DEFAULT_MULT, 18, multiplier programmed by the automatic power-up sequence (1..255)
FB_ADDR, 8'h04, MD register address of the feedback divider
RST_CYCLES, 16, mdclk cycles PLL reset is held before MD writes
LOCK_TIMEOUT, 65535, mdclk cycles allowed for lock after reset release (16-bit counter)
AUTO_INIT, 1, 1 = run the sequence with DEFAULT_MULT right after reset

Ports:
mdclk  in  1  controller clock, also drives the PLL MD port
rst_n  in  1  asynchronous active-low reset
cfg_req  in  1  reconfiguration request; level, held until cfg_ack
cfg_mult  in  8  requested multiplier, sampled on the cycle the request is accepted
cfg_ack  out  1  one-cycle pulse when a request is accepted
pll_rst  out  1  PLL reset, active-high
pll_lock  in  1  raw PLL lock, asynchronous
mdopc  out  2  MD opcode: 00 nop, 01 write, 10 read, 11 address load
mdainc  out  1  MD address auto-increment strobe
mdwdi  out  8  MD write data / address
mdrdo  in  8  MD read data, valid one cycle after a read opcode
lock  out  1  qualified lock
busy  out  1  sequence in progress
err  out  1  sticky failure: timeout or readback mismatch

Behaviour:
- Reset values: pll_rst=1, mdopc=00, mdainc=0, mdwdi=0, cfg_ack=0, lock=0, busy=0, err=0. The FSM is in IDLE, or in RST_HOLD when AUTO_INIT=1.
- pll_lock passes through a 2-flop synchronizer before use. lock = synced pll_lock AND state==DONE.
- FSM states: IDLE, RST_HOLD, ADDR, WRITE, READ, CHECK, RELEASE, WAIT_LOCK, DONE, FAIL.
- IDLE/DONE/FAIL with cfg_req=1:
  - pulse cfg_ack
  - latch cfg_mult
  - clear err
  - go to RST_HOLD
  - cfg_mult=0 is treated as 1.
- RST_HOLD: pll_rst=1. Count RST_CYCLES cycles, then go to ADDR.
- ADDR: one cycle, mdopc=11, mdwdi=FB_ADDR.
- WRITE: one cycle, mdopc=01, mdwdi=mult-1 (divider encoding). Then go to READ.
- READ: one cycle, mdopc=10. CHECK on the next cycle compares mdrdo with mult-1.
  - match: go to RELEASE
  - mismatch: err=1, go to FAIL
- RELEASE: pll_rst deasserts this cycle. The timeout counter is cleared.
- WAIT_LOCK:
  - synced lock=1: go to DONE
  - counter reaches LOCK_TIMEOUT: err=1, go to FAIL
- DONE: busy=0. If synced lock drops in DONE, lock follows it low combinationally from the sync register. The FSM does not restart on its own.
- FAIL: pll_rst=1, busy=0. Wait for cfg_req.
- busy=1 in every state except IDLE, DONE and FAIL.
- pll_rst=1 in every state except RELEASE, WAIT_LOCK and DONE.
- mdopc=00 and mdainc=0 in all states not listed above.
- cfg_req while busy: ignored, no ack. The request stays pending and is accepted on the first cycle in DONE/FAIL.
- rst_n low mid-sequence: returns immediately to reset values. The PLL reverts to reset, so no partial MD write can leave it running.
- Latency, request to cfg_ack: 1 cycle.
- Latency, request to pll_rst release: 1 + RST_CYCLES + 4 cycles with readback, RST_CYCLES + 3 without.

Optional Feature:
PLL_MD_READBACK_EN.
- Defined: the READ/CHECK states exist, and a readback mismatch sets err.
- Undefined: WRITE goes directly to RELEASE. mdopc never issues 10, mdrdo is unused, and err reports timeout only.

Decomposition:
- Shared package pll_md_pkg:
  - MD opcode constants: MD_NOP, MD_WR, MD_RD, MD_ADDR
  - FSM state enum
  - FB_ADDR default
- One sub-module: pll_lock_sync (2-flop synchronizer, async active-low reset, output 0 in reset). Everything else stays inline.

Test Plan:
1. AUTO_INIT=1, PLL model locks 200 cycles after reset release:
   - MD trace ADDR 04, WR 11h (mult 18-1), then RD
   - pll_rst held ≥16 cycles
   - lock=1 and busy=0 after the sync delay; err=0
2. In DONE, cfg_req with cfg_mult=25:
   - cfg_ack for exactly one cycle
   - pll_rst reasserts, WR 18h, then lock again
3. Lock model never asserts, LOCK_TIMEOUT=100:
   - err=1 and FAIL exactly 100 cycles after entering WAIT_LOCK
   - pll_rst=1, lock=0
4. PLL_MD_READBACK_EN defined, model returns 00h on read: err=1, FAIL, pll_rst never released.
5. cfg_req asserted during WAIT_LOCK: no ack until DONE, then ack and restart. rst_n pulsed low during WRITE: all outputs return to reset values in the same cycle.
6. cfg_mult=0: WR data 00h (treated as 1). pll_lock glitching async: lock only changes after 2 cycles.
